// File: rtl/dlx_pkg.sv
// Shared DLX definitions for the GPR write path: register widths, the queued
// write entry, and the hard-wired zero register.
package dlx_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int GPR_DATA_W = 32;

  localparam logic [GPR_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [GPR_ADDR_W-1:0] rd;
    logic [GPR_DATA_W-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/gpr_fwd_lookup.sv
// Newest-match search over the pending write entries for one register read
// port. Slots are scanned head-to-tail, so the youngest match wins.
module gpr_fwd_lookup
  import dlx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wq_entry_t                   entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]    head,
  input  logic [$clog2(DEPTH):0]      count,
  input  logic [GPR_ADDR_W-1:0]       rs,
  output logic                        hit,
  output logic [GPR_DATA_W-1:0]       data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]      slot_match;
  logic [GPR_DATA_W-1:0] slot_data [DEPTH];

  // Slot gi is the entry gi positions younger than the head.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      localparam logic [PW:0] OFFSET = CW'(gi);
      logic [PW-1:0] idx;
      assign idx             = head + OFFSET[PW-1:0];
      assign slot_match[gi]  = (OFFSET < count) && (entries[idx].rd == rs) && (rs != REG_ZERO);
      assign slot_data[gi]   = entries[idx].data;
    end
  endgenerate

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_match[k]) begin
        hit  = 1'b1;
        data = slot_data[k];
      end
    end
  end

endmodule

// File: rtl/gpr_write_queue.sv
// In-order write queue feeding the DLX register file write port, with
// forwarding of pending writes to both read ports. Optional statistics
// counters are compiled in with GPR_WQ_STATS_EN.
module gpr_write_queue
  import dlx_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_rd,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic [ADDR_W-1:0]        ws,
  output logic                     we,
  output logic [DATA_W-1:0]        wData,
  input  logic [ADDR_W-1:0]        rs1,
  input  logic [ADDR_W-1:0]        rs2,
  output logic                     fwd1_hit,
  output logic [DATA_W-1:0]        fwd1_data,
  output logic                     fwd2_hit,
  output logic [DATA_W-1:0]        fwd2_data,
  output logic [$clog2(DEPTH):0]   pending
`ifdef GPR_WQ_STATS_EN
  ,
  output logic [15:0]              full_stall_cnt,
  output logic [15:0]              r0_drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;

  wq_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic      accept;
  logic      store;
  logic      pop;
  wq_entry_t wr_entry;
  wq_entry_t head_entry;

  assign in_ready   = (count_q != FULL_CNT);
  assign pop        = (count_q != '0);
  assign accept     = in_valid && in_ready;
  // r0 requests complete the handshake but never occupy a slot.
  assign store      = accept && (in_rd != REG_ZERO);
  assign wr_entry   = '{rd: in_rd, data: in_data};
  assign head_entry = mem_q[head_q];

  always_comb begin
    head_d  = pop   ? head_q + PTR_ONE : head_q;
    tail_d  = store ? tail_q + PTR_ONE : tail_q;
    count_d = count_q;
    case ({store, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[tail_q] <= wr_entry;
    end
  end

  assign we      = pop;
  assign ws      = pop ? head_entry.rd   : '0;
  assign wData   = pop ? head_entry.data : '0;
  assign pending = count_q;

  gpr_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (mem_q),
    .head    (head_q),
    .count   (count_q),
    .rs      (rs1),
    .hit     (fwd1_hit),
    .data    (fwd1_data)
  );

  gpr_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (mem_q),
    .head    (head_q),
    .count   (count_q),
    .rs      (rs2),
    .hit     (fwd2_hit),
    .data    (fwd2_data)
  );

`ifdef GPR_WQ_STATS_EN
  logic [15:0] full_stall_cnt_q, full_stall_cnt_d;
  logic [15:0] r0_drop_cnt_q, r0_drop_cnt_d;

  always_comb begin
    full_stall_cnt_d = full_stall_cnt_q;
    r0_drop_cnt_d    = r0_drop_cnt_q;
    if (in_valid && !in_ready && (full_stall_cnt_q != 16'hFFFF)) begin
      full_stall_cnt_d = full_stall_cnt_q + 16'd1;
    end
    if (accept && (in_rd == REG_ZERO) && (r0_drop_cnt_q != 16'hFFFF)) begin
      r0_drop_cnt_d = r0_drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_stall_cnt_q <= '0;
      r0_drop_cnt_q    <= '0;
    end else begin
      full_stall_cnt_q <= full_stall_cnt_d;
      r0_drop_cnt_q    <= r0_drop_cnt_d;
    end
  end

  assign full_stall_cnt = full_stall_cnt_q;
  assign r0_drop_cnt    = r0_drop_cnt_q;
`endif

endmodule
